fifo_pack_memory: RTL and testbench

//  - Width-up FIFO: gathers DATA_IN_WIDTH-bit items (4-bit activations) into DATA_OUT_WIDTH-bit words (16-bit), buffers DEPTH words.
//  - Inverse of the nibble-unpacking FIFO; sits on the result path between neuron outputs and the 16-bit writeback bus.

---
 rtl/nn_fifo_pkg.sv | 34 +++
 rtl/fifo_word_ram.sv | 48 ++++
 rtl/fifo_pack_memory.sv | 147 ++++++++++++++
 tb/tb_fifo_pack_memory.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : nn_fifo_pkg
//  Description : Shared constants and helpers for the neural-network result
//                FIFOs: default activation/bus widths, the pack ratio and a
//                constant ceil(log2) function used for pointer sizing.
//  Revision    : 1.0 - initial release
// ============================================================================
package nn_fifo_pkg;

    localparam int NN_ACT_WIDTH = 4;
    localparam int NN_BUS_WIDTH = 16;
    localparam int NN_RATIO     = NN_BUS_WIDTH / NN_ACT_WIDTH;

    // ceil(log2(value)); returns 0 for value <= 1
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    // Number of input items gathered into one packed word
    function automatic int pack_ratio(input int out_width, input int in_width);
        return out_width / in_width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_word_ram.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_word_ram
//  Description : DEPTH x WIDTH word store, one write port and one read port
//                with a registered output. The array itself is not reset;
//                only the read register clears on rst.
//  Ports       : clk, rst          - clock, async active-high reset
//                i_wr_en/i_wr_addr/i_wr_data - write port
//                i_rd_en/i_rd_addr - read request, data appears next cycle
//                o_rd_data         - registered read data (holds when idle)
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_word_ram #(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]  i_wr_data,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [WIDTH-1:0]  o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/fifo_pack_memory.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_pack_memory
//  Description : Width-up FIFO. Gathers DATA_IN_WIDTH-bit items into
//                DATA_OUT_WIDTH-bit words (first item in the LSBs) and
//                buffers up to DEPTH complete words.
//  Ports       : clk, rst           - clock, async active-high reset
//                wr_en, data_in     - push one item (ignored while full)
//                rd_en              - pop one word (ignored while empty)
//                data_out           - registered packed word, holds when idle
//                valid_out          - 1-cycle pulse when data_out updated
//                empty / full       - no complete word / DEPTH words stored
//                flush, partial     - only with FIFO_PACK_FLUSH_EN defined:
//                                     flush writes a zero-padded partial
//                                     word; partial = assembly in progress
//  Config      : `define FIFO_PACK_FLUSH_EN to enable flush/partial ports.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_pack_memory
    import nn_fifo_pkg::*;
#(
    parameter int DATA_IN_WIDTH  = NN_ACT_WIDTH,
    parameter int DATA_OUT_WIDTH = NN_BUS_WIDTH,
    parameter int DEPTH          = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [DATA_IN_WIDTH-1:0]  data_in,
    input  logic                      rd_en,
    output logic [DATA_OUT_WIDTH-1:0] data_out,
    output logic                      valid_out,
    output logic                      empty,
    output logic                      full
`ifdef FIFO_PACK_FLUSH_EN
    ,
    input  logic                      flush,
    output logic                      partial
`endif
);

    localparam int c_ratio  = pack_ratio(DATA_OUT_WIDTH, DATA_IN_WIDTH);
    localparam int c_slot_w = (c_ratio > 1) ? clog2(c_ratio) : 1;
    localparam int c_ptr_w  = clog2(DEPTH);
    localparam int c_cnt_w  = c_ptr_w + 1;

    localparam logic [c_slot_w-1:0] c_last_slot  = c_slot_w'(c_ratio - 1);
    localparam logic [c_cnt_w-1:0]  c_full_count = c_cnt_w'(DEPTH);

    logic [c_slot_w-1:0]       r_slot;
    logic [DATA_OUT_WIDTH-1:0] r_asm;
    logic [c_ptr_w-1:0]        r_wr_ptr;
    logic [c_ptr_w-1:0]        r_rd_ptr;
    logic [c_cnt_w-1:0]        r_count;
    logic                      r_valid;

    logic                      w_push;
    logic                      w_pop;
    logic                      w_word_done;
    logic                      w_flush;
    logic                      w_wr_word;
    logic [DATA_OUT_WIDTH-1:0] w_asm_next;

    assign empty = (r_count == '0);
    assign full  = (r_count == c_full_count);

    // A push while full is dropped entirely, even if a pop frees space this
    // cycle: the flag is the registered count, not a look-ahead.
    assign w_push      = wr_en && !full;
    assign w_pop       = rd_en && !empty;
    assign w_word_done = w_push && (r_slot == c_last_slot);

`ifdef FIFO_PACK_FLUSH_EN
    // Flush only acts on a partial word; the same-cycle item is merged first,
    // so flush together with the completing item still writes one word.
    assign w_flush = flush && !full && (r_slot != '0);
    assign partial = (r_slot != '0);
`else
    assign w_flush = 1'b0;
`endif

    assign w_wr_word = w_word_done || w_flush;

    // Assembly with the current item dropped into its slot. Upper slots are
    // still zero, which gives the padding for a flushed word for free.
    always_comb begin
        w_asm_next = r_asm;
        for (int k = 0; k < c_ratio; k++) begin
            if (w_push && (r_slot == c_slot_w'(k))) begin
                w_asm_next[k*DATA_IN_WIDTH +: DATA_IN_WIDTH] = data_in;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_slot   <= '0;
            r_asm    <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_valid  <= 1'b0;
        end else begin
            if (w_wr_word) begin
                r_slot   <= '0;
                r_asm    <= '0;
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end else if (w_push) begin
                r_slot   <= r_slot + c_slot_w'(1);
                r_asm    <= w_asm_next;
            end

            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end

            case ({w_wr_word, w_pop})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase

            r_valid <= w_pop;
        end
    end

    assign valid_out = r_valid;

    // Write and read addresses never collide: a pop needs a stored word at
    // rd_ptr, a write needs a free entry at wr_ptr.
    fifo_word_ram #(
        .WIDTH  (DATA_OUT_WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (c_ptr_w)
    ) u_word_ram (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_wr_word),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (w_asm_next),
        .i_rd_en   (w_pop),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (data_out)
    );

endmodule
`default_nettype wire

// File: tb/tb_fifo_pack_memory.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_pack_memory
//  Description : Self-checking bench for fifo_pack_memory. A vector table
//                covers the basic pack/pop and partial-word cases; a
//                behavioural model with a word queue covers fill, overflow,
//                simultaneous push/pop across pointer wrap and random traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_pack_memory;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [3:0]  data_in;
    logic        rd_en;
    logic [15:0] data_out;
    logic        valid_out;
    logic        empty;
    logic        full;
`ifdef FIFO_PACK_FLUSH_EN
    logic        flush;
    logic        partial;
`endif

    int errors = 0;
    int checks = 0;

    // Behavioural model state
    logic [15:0] m_asm;
    int          m_slot;
    logic [15:0] sb[$];
    logic [15:0] m_dout;
    logic        m_valid;

    typedef struct packed {
        logic        wr;
        logic [3:0]  din;
        logic        rd;
        logic        exp_valid;
        logic [15:0] exp_dout;
        logic        exp_empty;
        logic        exp_full;
    } vec_t;

    vec_t vecs [11];

    fifo_pack_memory #(
        .DATA_IN_WIDTH  (4),
        .DATA_OUT_WIDTH (16),
        .DEPTH          (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .data_in   (data_in),
        .rd_en     (rd_en),
        .data_out  (data_out),
        .valid_out (valid_out),
        .empty     (empty),
        .full      (full)
`ifdef FIFO_PACK_FLUSH_EN
        ,
        .flush     (flush),
        .partial   (partial)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_asm   = '0;
        m_slot  = 0;
        sb.delete();
        m_dout  = '0;
        m_valid = 1'b0;
    endtask

    task automatic model_step(input logic wr, input logic [3:0] din, input logic rd, input logic fl);
        bit full_pre;
        bit empty_pre;
        int slot_pre;
        full_pre  = (sb.size() == 8);
        empty_pre = (sb.size() == 0);
        slot_pre  = m_slot;
        m_valid   = 1'b0;
        if (rd && !empty_pre) begin
            m_dout  = sb.pop_front();
            m_valid = 1'b1;
        end
        if (wr && !full_pre) begin
            m_asm[m_slot*4 +: 4] = din;
            m_slot++;
        end
        if (m_slot == 4 || (fl && !full_pre && slot_pre != 0)) begin
            sb.push_back(m_asm);
            m_asm  = '0;
            m_slot = 0;
        end
    endtask

    task automatic drive(input logic wr, input logic [3:0] din, input logic rd, input logic fl);
        wr_en   = wr;
        data_in = din;
        rd_en   = rd;
`ifdef FIFO_PACK_FLUSH_EN
        flush   = fl;
`endif
    endtask

    // One clock with model comparison of every output after the edge
    task automatic cycle(input logic wr, input logic [3:0] din, input logic rd, input logic fl);
        drive(wr, din, rd, fl);
        @(posedge clk);
        model_step(wr, din, rd, fl);
        #1;
        check("valid_out", valid_out, m_valid);
        check("data_out", data_out, m_dout);
        check("empty", empty, sb.size() == 0);
        check("full", full, sb.size() == 8);
`ifdef FIFO_PACK_FLUSH_EN
        check("partial", partial, m_slot != 0);
`endif
        drive(1'b0, 4'h0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        drive(1'b0, 4'h0, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        model_reset();
        check("rst_empty", empty, 1'b1);
        check("rst_full", full, 1'b0);
        check("rst_data_out", data_out, 16'h0000);
        check("rst_valid_out", valid_out, 1'b0);
`ifdef FIFO_PACK_FLUSH_EN
        check("rst_partial", partial, 1'b0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        drive(1'b0, 4'h0, 1'b0, 1'b0);
        @(posedge clk);
        #1;

        // Test 1: reset state
        do_reset();

        // Tests 2 and 3: pack D,C,B,A -> 0xABCD; then a 3-item partial word
        vecs[0]  = '{1'b1, 4'hD, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[1]  = '{1'b1, 4'hC, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 4'hB, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[3]  = '{1'b1, 4'hA, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 4'h0, 1'b1, 1'b1, 16'hABCD, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 4'h0, 1'b0, 1'b0, 16'hABCD, 1'b1, 1'b0};
        vecs[6]  = '{1'b1, 4'h1, 1'b0, 1'b0, 16'hABCD, 1'b1, 1'b0};
        vecs[7]  = '{1'b1, 4'h2, 1'b0, 1'b0, 16'hABCD, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 4'h3, 1'b0, 1'b0, 16'hABCD, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 4'h0, 1'b1, 1'b0, 16'hABCD, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 4'h0, 1'b0, 1'b0, 16'hABCD, 1'b1, 1'b0};
        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].wr, vecs[i].din, vecs[i].rd, 1'b0);
            @(posedge clk);
            model_step(vecs[i].wr, vecs[i].din, vecs[i].rd, 1'b0);
            #1;
            check($sformatf("vec%0d_valid", i), valid_out, vecs[i].exp_valid);
            check($sformatf("vec%0d_dout", i), data_out, vecs[i].exp_dout);
            check($sformatf("vec%0d_empty", i), empty, vecs[i].exp_empty);
            check($sformatf("vec%0d_full", i), full, vecs[i].exp_full);
        end

        // Reset with 3 items pending discards them
        do_reset();

        // Test 4: fill to full, overflow ignored, drain in order
        for (int w = 0; w < 8; w++) begin
            for (int k = 0; k < 4; k++) begin
                cycle(1'b1, 4'(w), 1'b0, 1'b0);
            end
        end
        check("full_after_32", full, 1'b1);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 4'hF, 1'b0, 1'b0);
        end
        for (int w = 0; w < 8; w++) begin
            cycle(1'b0, 4'h0, 1'b1, 1'b0);
            check("fill_pop_word", data_out, 32'(w * 16'h1111));
        end
        cycle(1'b0, 4'h0, 1'b1, 1'b0);
        check("ninth_pop_valid", valid_out, 1'b0);
        check("ninth_pop_data", data_out, 16'h7777);

        // Test 5: DEPTH-1 words, then word completion coinciding with a pop
        do_reset();
        for (int i = 0; i < 28; i++) begin
            cycle(1'b1, 4'($urandom), 1'b0, 1'b0);
        end
        for (int n = 0; n < 12; n++) begin
            for (int k = 0; k < 3; k++) begin
                cycle(1'b1, 4'($urandom), 1'b0, 1'b0);
            end
            cycle(1'b1, 4'($urandom), 1'b1, 1'b0);
            check("simul_not_full", full, 1'b0);
            check("simul_not_empty", empty, 1'b0);
            check("simul_valid", valid_out, 1'b1);
        end
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 4'h0, 1'b1, 1'b0);
        end
        check("drained_empty", empty, 1'b1);

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            cycle(1'($urandom), 4'($urandom), 1'($urandom_range(0, 3) == 0), 1'b0);
        end

`ifdef FIFO_PACK_FLUSH_EN
        // Test 6: flush a 2-item word, flush with concurrent item, reset drop
        do_reset();
        cycle(1'b1, 4'h5, 1'b0, 1'b0);
        cycle(1'b1, 4'h6, 1'b0, 1'b0);
        check("partial_set", partial, 1'b1);
        cycle(1'b0, 4'h0, 1'b0, 1'b1);
        check("flush_not_empty", empty, 1'b0);
        cycle(1'b0, 4'h0, 1'b1, 1'b0);
        check("flush_word", data_out, 16'h0065);
        cycle(1'b0, 4'h0, 1'b0, 1'b1);
        check("flush_idle_empty", empty, 1'b1);
        cycle(1'b1, 4'h7, 1'b0, 1'b0);
        cycle(1'b1, 4'h8, 1'b0, 1'b1);
        cycle(1'b0, 4'h0, 1'b1, 1'b0);
        check("flush_with_item", data_out, 16'h0087);
        cycle(1'b1, 4'h1, 1'b0, 1'b0);
        cycle(1'b1, 4'h2, 1'b0, 1'b0);
        do_reset();
        check("partial_after_rst", partial, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
